// File: rtl/cpu_types_pkg.sv
// Shared datapath/cache types: machine word, instruction-cache frame and
// responder state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Tags are held zero-extended to the full word-address width so one frame
    // type serves every SETS choice.
    localparam int WORD_ADDR_W = 30;

    typedef struct packed {
        logic                   valid;
        logic [WORD_ADDR_W-1:0] tag;
        word_t                  data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: async-reset valid bits, tag and data words,
// one combinational read port and one write port.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [IDX_W-1:0]  ridx,
    output icache_frame_t     rframe,
    input  logic              wen,
    input  logic [IDX_W-1:0]  widx,
    input  logic [TAG_W-1:0]  wtag,
    input  word_t             wdata
);

    logic [SETS-1:0]  valid_reg;
    logic [TAG_W-1:0] tag_mem  [SETS];
    word_t            data_mem [SETS];

    // Only the valid bits need clearing; stale tag/data is masked by valid=0.
    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wen && (widx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (wen) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata;
        end
    end

    always_comb begin
        rframe       = '0;
        rframe.valid = valid_reg[ridx];
        rframe.tag   = WORD_ADDR_W'(tag_mem[ridx]);
        rframe.data  = data_mem[ridx];
    end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block instruction cache: zero-latency hits, and a
// blocking fill from the memory controller on a miss.
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 2 - IDX_W;

    icache_state_t    state_reg, state_next;
    logic [29:0]      miss_word_reg;
    logic [31:0]      hit_count_reg, miss_count_reg;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    icache_frame_t    rframe;
    logic             hit, miss_start, fill;
    logic             unused_byte_offset;

    assign idx = imemaddr[IDX_W+1:2];
    assign tag = imemaddr[31:IDX_W+2];
    assign unused_byte_offset = ^imemaddr[1:0];

    // A frame is written only on the completing FETCH cycle, never while IDLE
    // lookups are live, so there is no read/write collision to bypass.
    assign fill = (state_reg == FETCH) && !iwait;

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .CLK    (CLK),
        .nRST   (nRST),
        .ridx   (idx),
        .rframe (rframe),
        .wen    (fill),
        .widx   (miss_word_reg[IDX_W-1:0]),
        .wtag   (miss_word_reg[29:IDX_W]),
        .wdata  (iload)
    );

    assign hit = (state_reg == IDLE) && imemREN && rframe.valid
                 && (rframe.tag == WORD_ADDR_W'(tag));

    always_comb begin
        state_next = state_reg;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        miss_start = 1'b0;
        if (state_reg == IDLE) begin
            if (hit) begin
                ihit     = 1'b1;
                imemload = rframe.data;
            end else if (imemREN) begin
                miss_start = 1'b1;
                state_next = FETCH;
            end
        end else begin
            iREN  = 1'b1;
            iaddr = {miss_word_reg, 2'b00};
            if (!iwait) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            miss_word_reg  <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (miss_start) begin
                miss_word_reg <= imemaddr[31:2];
            end
            if (hit && (hit_count_reg != '1)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss_start && (miss_count_reg != '1)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: stimulus queues expected hits and
// fills, a negedge monitor pops and compares them as the DUT presents them.
module tb_icache_responder;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] hit_q[$];
    logic [31:0] fetch_q[$];

    icache_responder #(.SETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a hit or completes a fill.
    always @(negedge CLK) begin
        if (nRST) begin
            if (ihit) begin
                if (hit_q.size() == 0) begin
                    check("unexpected_ihit", imemaddr, 32'hFFFF_FFFF);
                end else begin
                    check("imemload", imemload, hit_q.pop_front());
                end
            end
            if (iREN && !iwait) begin
                if (fetch_q.size() == 0) begin
                    check("unexpected_fill", iaddr, 32'hFFFF_FFFF);
                end else begin
                    check("fill_iaddr", iaddr, fetch_q.pop_front());
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        imemREN = 1'b0;
        imemaddr = '0;
        iwait = 1'b1;
        iload = '0;
        next_cycle();
        next_cycle();
        nRST = 1'b1;
    endtask

    // One miss cycle, then `waits` busy cycles and one data cycle; imemaddr and
    // imemREN may be changed during the fetch via fetch_ren/fetch_addr.
    task automatic fill(input logic [31:0] addr, input int waits, input logic [31:0] data,
                        input logic fetch_ren, input logic [31:0] fetch_addr,
                        input logic [31:0] exp_miss);
        logic [31:0] aligned;
        aligned = {addr[31:2], 2'b00};
        imemREN = 1'b1;
        imemaddr = addr;
        iwait = 1'b1;
        #2;
        check("miss_ihit", {31'd0, ihit}, 32'd0);
        next_cycle();
        fetch_q.push_back(aligned);
        imemREN = fetch_ren;
        imemaddr = fetch_addr;
        for (int i = 0; i <= waits; i++) begin
            iwait = (i < waits);
            iload = (i < waits) ? 32'h0 : data;
            #2;
            check("fetch_iREN", {31'd0, iREN}, 32'd1);
            check("fetch_iaddr", iaddr, aligned);
            next_cycle();
        end
        iwait = 1'b1;
        iload = '0;
        imemREN = 1'b0;
        check("miss_count", miss_count, exp_miss);
        $display("fill addr=%h data=%h waits=%0d", addr, data, waits);
    endtask

    task automatic hit_cycle(input logic [31:0] addr, input logic [31:0] data);
        imemREN = 1'b1;
        imemaddr = addr;
        hit_q.push_back(data);
        next_cycle();
        check("hit_seen", hit_q.size(), 32'd0);
        hit_q.delete();
        imemREN = 1'b0;
        $display("hit  addr=%h data=%h", addr, data);
    endtask

    initial begin
        nRST = 1'b0;
        imemREN = 1'b0;
        imemaddr = '0;
        iwait = 1'b1;
        iload = '0;
        #2;
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_iREN", {31'd0, iREN}, 32'd0);
        do_reset();
        #1;
        check("rst_iaddr", iaddr, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        next_cycle();

        // Cold miss with three wait cycles, then three hits
        fill(32'h0000_0004, 3, 32'h8C22_0000, 1'b1, 32'h0000_0004, 32'd1);
        hit_cycle(32'h0000_0004, 32'h8C22_0000);
        hit_cycle(32'h0000_0004, 32'h8C22_0000);
        hit_cycle(32'h0000_0004, 32'h8C22_0000);
        check("cold_hit_count", hit_count, 32'd3);

        // Conflict miss on index 0
        do_reset();
        fill(32'h0000_0000, 0, 32'h1111_1111, 1'b1, 32'h0000_0000, 32'd1);
        hit_cycle(32'h0000_0000, 32'h1111_1111);
        fill(32'h0000_0040, 0, 32'h2222_2222, 1'b1, 32'h0000_0040, 32'd2);
        hit_cycle(32'h0000_0040, 32'h2222_2222);
        fill(32'h0000_0000, 0, 32'h1111_1111, 1'b1, 32'h0000_0000, 32'd3);
        check("conflict_hit_count", hit_count, 32'd2);

        // Address change while fetching
        do_reset();
        fill(32'h0000_0010, 1, 32'hA5A5_A5A5, 1'b1, 32'h0000_0020, 32'd1);
        fill(32'h0000_0020, 0, 32'h5A5A_5A5A, 1'b1, 32'h0000_0020, 32'd2);
        hit_cycle(32'h0000_0010, 32'hA5A5_A5A5);
        hit_cycle(32'h0000_0020, 32'h5A5A_5A5A);

        // Request dropped during fetch
        do_reset();
        fill(32'h0000_0008, 2, 32'h0BAD_F00D, 1'b0, 32'h0000_0008, 32'd1);
        imemREN = 1'b0;
        imemaddr = 32'h0000_0008;
        #2;
        check("dropped_ihit", {31'd0, ihit}, 32'd0);
        check("dropped_imemload", imemload, 32'd0);
        next_cycle();
        hit_cycle(32'h0000_0008, 32'h0BAD_F00D);
        check("dropped_hit_count", hit_count, 32'd1);

        // Reset pulsed in the middle of a fetch
        do_reset();
        imemREN = 1'b1;
        imemaddr = 32'h0000_000C;
        next_cycle();
        #2;
        check("prerst_iREN", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        check("midrst_iREN", {31'd0, iREN}, 32'd0);
        check("midrst_iaddr", iaddr, 32'd0);
        check("midrst_miss_count", miss_count, 32'd0);
        check("midrst_hit_count", hit_count, 32'd0);
        next_cycle();
        nRST = 1'b1;
        imemREN = 1'b0;
        next_cycle();
        fill(32'h0000_000C, 0, 32'h1357_2468, 1'b1, 32'h0000_000C, 32'd1);
        hit_cycle(32'h0000_000C, 32'h1357_2468);

        // Unaligned request hits the aligned frame
        fill(32'h0000_0014, 0, 32'hDEAD_BEEF, 1'b1, 32'h0000_0014, 32'd2);
        hit_cycle(32'h0000_0017, 32'hDEAD_BEEF);
        check("unaligned_hit_count", hit_count, 32'd2);

        next_cycle();
        check("fetch_q_drained", fetch_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
